// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use bubbles, multi-cycle branch flushes and
// memory wait-state freezes, plus saturating hazard statistics.
//   state    | meaning
//   ST_RUN   | normal issue; branch and load-use detection active
//   ST_FLUSH | squashing wrong-path fetches; fcnt counts remaining flush cycles
module hazard_controller #(
  parameter int BRANCH_PENALTY = 1,
  parameter int TIMEOUT        = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [2:0]       FCNT_INIT = 3'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] loaduse_q, loaduse_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] memwait_q, memwait_d;

  logic mem_stall;
  logic load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    wait_d      = '0;
    timeout_d   = timeout_q;
    loaduse_d   = loaduse_q;
    flush_d     = flush_q;
    memwait_d   = memwait_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;

    if (!rst) begin
      if (mem_stall) begin
        // Freeze everything; a pending branch or load-use is seen again once memory is ready.
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
        memwait_d   = sat_inc(memwait_q);
        wait_d      = sat_inc(wait_q);
        if (wait_d == TIMEOUT_C) timeout_d = 1'b1;
      end else if (state_q == ST_FLUSH) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_d    = sat_inc(flush_q);
        fcnt_d     = fcnt_q - 3'd1;
        if (fcnt_q == 3'd1) state_d = ST_RUN;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_d    = sat_inc(flush_q);
        if (BRANCH_PENALTY > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_INIT;
        end
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        loaduse_d  = sat_inc(loaduse_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      loaduse_q <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      loaduse_q <= loaduse_d;
      flush_q   <= flush_d;
      memwait_q <= memwait_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign loaduse_cnt = loaduse_q;
  assign flush_cnt   = flush_q;
  assign memwait_cnt = memwait_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_hazard_controller;
  localparam int BP   = 3;
  localparam int TO   = 8;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic          exmem_stall, memwb_flush, mem_timeout;
  logic [CW-1:0] loaduse_cnt, flush_cnt, memwait_cnt;

  hazard_controller #(.BRANCH_PENALTY(BP), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .mem_timeout(mem_timeout),
    .loaduse_cnt(loaduse_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: remaining flush cycles after the current one, run length of memory wait, stats.
  int m_left = 0, m_wait = 0, m_lu = 0, m_fl = 0, m_mw = 0;
  bit m_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_regwrite = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs, input logic use1);
    ex_memread = 1; ex_regwrite = 1; ex_rd = rd; id_rs1 = rs; id_use_rs1 = use1;
  endtask

  // One clock: inputs already driven just after the previous edge; check mid-cycle,
  // advance the model, then move past the next rising edge.
  task automatic cycle(input string tag);
    logic [6:0] exp_o;
    bit ms, lu;
    #3;
    ms = mem_req && !mem_ready;
    lu = ex_memread && ex_regwrite && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush
    exp_o = 7'b0;
    if (!rst) begin
      if (ms)                   exp_o = 7'b1101011;
      else if (m_left > 0)      exp_o = 7'b0010100;
      else if (ex_branch_taken) exp_o = 7'b0010100;
      else if (lu)              exp_o = 7'b1100100;
    end
    check({tag, ".outs"}, 32'({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                              exmem_stall, memwb_flush}), 32'(exp_o));
    check({tag, ".loaduse_cnt"}, 32'(loaduse_cnt), 32'(m_lu));
    check({tag, ".flush_cnt"},   32'(flush_cnt),   32'(m_fl));
    check({tag, ".memwait_cnt"}, 32'(memwait_cnt), 32'(m_mw));
    check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_to));

    if (rst) begin
      m_left = 0; m_wait = 0; m_lu = 0; m_fl = 0; m_mw = 0; m_to = 0;
    end else if (ms) begin
      m_mw   = (m_mw < MAXC) ? m_mw + 1 : MAXC;
      m_wait = m_wait + 1;
      if (m_wait >= TO) m_to = 1;
    end else begin
      m_wait = 0;
      if (m_left > 0) begin
        m_left--;
        m_fl = (m_fl < MAXC) ? m_fl + 1 : MAXC;
      end else if (ex_branch_taken) begin
        m_left = BP - 1;
        m_fl = (m_fl < MAXC) ? m_fl + 1 : MAXC;
      end else if (lu) begin
        m_lu = (m_lu < MAXC) ? m_lu + 1 : MAXC;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;

    // Reset holds outputs low even with a memory stall and a branch presented.
    mem_req = 1; ex_branch_taken = 1;
    cycle("reset0");
    cycle("reset1");
    idle();
    rst = 0;
    cycle("idle");

    set_load_use(5'd5, 5'd5, 1'b1);
    cycle("lu_hit");
    idle();
    cycle("lu_after");
    set_load_use(5'd0, 5'd0, 1'b1);
    cycle("lu_x0");
    set_load_use(5'd5, 5'd5, 1'b0);
    cycle("lu_nouse");
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
    cycle("lu_rs2");
    idle();

    ex_branch_taken = 1;
    cycle("br_c1");
    ex_branch_taken = 0;
    set_load_use(5'd3, 5'd3, 1'b1);
    cycle("br_c2");
    cycle("br_c3");
    idle();
    cycle("br_done");

    mem_req = 1;
    for (int i = 0; i < 4; i++) cycle("mw_wait");
    mem_ready = 1;
    cycle("mw_ready");
    idle();
    cycle("mw_done");

    ex_branch_taken = 1;
    cycle("sim_br");
    ex_branch_taken = 0; mem_req = 1;
    cycle("sim_wait1");
    cycle("sim_wait2");
    mem_req = 0;
    cycle("sim_fl2");
    cycle("sim_fl3");
    cycle("sim_run");
    ex_branch_taken = 1;
    set_load_use(5'd9, 5'd9, 1'b1);
    cycle("br_and_lu");
    idle();
    cycle("br_and_lu_f2");
    cycle("br_and_lu_f3");

    mem_req = 1;
    for (int i = 0; i < 10; i++) cycle("to_wait");
    mem_ready = 1;
    cycle("to_ready");
    idle();
    cycle("to_sticky0");
    cycle("to_sticky1");

    ex_branch_taken = 1;
    cycle("rmf_br");
    ex_branch_taken = 0;
    rst = 1;
    cycle("rmf_rst");
    rst = 0;
    cycle("rmf_run");
    ex_branch_taken = 1;
    cycle("rmf_f1");
    ex_branch_taken = 0;
    cycle("rmf_f2");
    cycle("rmf_f3");
    cycle("rmf_end");

    // Random traffic; small register range makes load-use matches frequent.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_regwrite     = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    rst = 0;
    idle();
    cycle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
